// File: rtl/moving_average_mc.sv
// Multi-channel moving-average filter: sliding or block (decimated) power-of-two
// window, shared control set, 2-cycle latency from accepted sample to result.
module moving_average_mc #(
    parameter int CHANNELS    = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_LEN_LOG = 10
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0]       in_data,
    input  logic [$clog2(MAX_LEN_LOG+1)-1:0]     len_log,
    input  logic                                 block_mode,
    input  logic                                 clear,
    output logic                                 out_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0]       out_data,
    output logic                                 filled
);
    localparam int LW    = $clog2(MAX_LEN_LOG + 1);
    localparam int CW    = MAX_LEN_LOG + 1;
    localparam int AW    = DATA_WIDTH + MAX_LEN_LOG;
    localparam int DEPTH = 1 << MAX_LEN_LOG;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_stateNext;
    logic [LW-1:0]                  w_effLen;
    logic [LW-1:0]                  r_activeLen;
    logic                           r_blockMode;
    logic                           w_restart;
    logic                           w_accept;
    logic [CW-1:0]                  w_lenVal;
    logic [CW-1:0]                  r_fillCnt;
    logic [CW-1:0]                  w_fillCntNext;
    logic [CW-1:0]                  r_blkCnt;
    logic [CW-1:0]                  w_blkCntNext;
    logic                           w_emit;
    logic [MAX_LEN_LOG-1:0]         r_wptr;
    logic [MAX_LEN_LOG-1:0]         w_raddr;
    logic                           r_s1Valid;
    logic                           r_s1Emit;
    logic                           r_s1Run;
    logic                           r_s1UseOld;
    logic [CHANNELS*DATA_WIDTH-1:0] r_s1Data;
    logic [CHANNELS*DATA_WIDTH-1:0] w_outNext;
    logic [CHANNELS*AW-1:0]         r_acc;
    logic [CHANNELS*AW-1:0]         w_accNext;

    assign w_effLen  = (len_log > LW'(MAX_LEN_LOG)) ? LW'(MAX_LEN_LOG) : len_log;
    assign w_restart = clear | (w_effLen != r_activeLen) | (block_mode != r_blockMode);
    assign w_accept  = in_valid & ~w_restart;
    assign w_lenVal  = CW'(1) << r_activeLen;
    // With L equal to the full depth the read address equals the write address;
    // the read-before-write buffer then returns the sample written DEPTH accepts ago.
    assign w_raddr   = r_wptr - w_lenVal[MAX_LEN_LOG-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= FILL;
            r_fillCnt   <= '0;
            r_blkCnt    <= '0;
            r_activeLen <= '0;
            r_blockMode <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_fillCnt <= w_fillCntNext;
            r_blkCnt  <= w_blkCntNext;
            if (w_restart) begin
                r_activeLen <= w_effLen;
                r_blockMode <= block_mode;
            end
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_fillCntNext = r_fillCnt;
        w_blkCntNext  = r_blkCnt;
        w_emit        = 1'b0;
        if (w_restart) begin
            w_stateNext   = FILL;
            w_fillCntNext = '0;
            w_blkCntNext  = '0;
        end else if (w_accept) begin
            case (r_state)
                FILL: begin
                    w_fillCntNext = r_fillCnt + CW'(1);
                    if (w_fillCntNext == w_lenVal) begin
                        w_stateNext = RUN;
                        w_emit      = 1'b1;
                    end
                end
                RUN: begin
                    if (!r_blockMode) begin
                        w_emit = 1'b1;
                    end else begin
                        w_blkCntNext = r_blkCnt + CW'(1);
                        if (w_blkCntNext == w_lenVal) begin
                            w_blkCntNext = '0;
                            w_emit       = 1'b1;
                        end
                    end
                end
                default: w_stateNext = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_s1Valid  <= 1'b0;
            r_s1Emit   <= 1'b0;
            r_s1Run    <= 1'b0;
            r_s1UseOld <= 1'b0;
            r_s1Data   <= '0;
        end else begin
            r_s1Valid <= w_accept;
            r_s1Emit  <= w_emit;
            if (w_accept) begin
                r_wptr     <= r_wptr + MAX_LEN_LOG'(1);
                r_s1Run    <= (w_stateNext == RUN);
                r_s1UseOld <= (r_state == RUN);
                r_s1Data   <= in_data;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [DATA_WIDTH-1:0] r_rdData;
        logic signed [AW-1:0]  w_x;
        logic signed [AW-1:0]  w_xOld;
        logic signed [AW-1:0]  w_sum;

        always_ff @(posedge clk) begin
            if (w_accept) begin
                r_mem[r_wptr] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
                r_rdData      <= r_mem[w_raddr];
            end
        end

        assign w_x    = AW'($signed(r_s1Data[k*DATA_WIDTH +: DATA_WIDTH]));
        assign w_xOld = r_s1UseOld ? AW'($signed(r_rdData)) : '0;
        assign w_sum  = r_acc[k*AW +: AW] + w_x - w_xOld;
        assign w_accNext[k*AW +: AW]                 = w_sum;
        assign w_outNext[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w_sum >>> r_activeLen);
    end

    // A restart on the same edge as an in-flight sample drops its result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            filled    <= 1'b0;
        end else if (w_restart) begin
            r_acc     <= '0;
            out_valid <= 1'b0;
            filled    <= 1'b0;
        end else begin
            out_valid <= r_s1Valid & r_s1Emit;
            if (r_s1Valid) begin
                r_acc <= w_accNext;
                if (r_s1Emit) begin
                    out_data <= w_outNext;
                end
                if (r_s1Run) begin
                    filled <= 1'b1;
                end
            end
        end
    end
endmodule
